barrel_shifter_pipe: RTL and testbench

- Parametrised, pipelined barrel shifter; successor to the 8-bit combinational shifter.
- Supports four modes: logical left, logical right, arithmetic right, rotate right.
- One register stage per shift-amount bit, so it closes timing at wide datapaths.
- Uses a valid/ready handshake on both sides, carries an opaque tag alongside the data, and feeds the ALU result path.

---
 rtl/barrel_shifter_pipe.sv | 163 ++++++++++++++++
 tb/tb_barrel_shifter_pipe.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROR) with a valid/ready handshake and a sideband tag.
// Define BARREL_SHIFTER_PIPE_FLAGS_EN to add the zero_out/carry_out result flags.
module barrel_shifter_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic [SHW-1:0]   shamt,
    input  logic [1:0]       op,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic [TAG_W-1:0] tag_out
`ifdef BARREL_SHIFTER_PIPE_FLAGS_EN
    ,
    output logic             zero_out,
    output logic             carry_out
`endif
);

    localparam logic [1:0]       OP_LSL = 2'b00;
    localparam logic [1:0]       OP_LSR = 2'b01;
    localparam logic [1:0]       OP_ASR = 2'b10;
    localparam logic [WIDTH-1:0] ONES   = '1;

    // Handshake: a beat moves in on in_valid && in_ready and out on out_valid && out_ready.
    // The whole pipe advances together whenever the output slot is empty or being drained.
    logic adv;

    assign adv      = out_ready || !out_valid;
    assign in_ready = adv;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int D   = 1 << k;
        localparam int SHR = SHW - k;

        logic             src_vld;
        logic [WIDTH-1:0] src_data;
        logic [1:0]       src_op;
        logic [SHR-1:0]   src_sh;
        logic             src_sign;
        logic [TAG_W-1:0] src_tag;

        logic             vld_q;
        logic [WIDTH-1:0] data_q;
        logic [WIDTH-1:0] data_d;
        logic [TAG_W-1:0] tag_q;

        if (k == 0) begin : g_first
            assign src_vld  = in_valid;
            assign src_data = din;
            assign src_op   = op;
            assign src_sh   = shamt;
            assign src_sign = din[WIDTH-1];
            assign src_tag  = tag_in;
        end else begin : g_next
            assign src_vld  = g_stage[k-1].vld_q;
            assign src_data = g_stage[k-1].data_q;
            assign src_op   = g_stage[k-1].g_ctl.op_q;
            assign src_sh   = g_stage[k-1].g_ctl.sh_q;
            assign src_sign = g_stage[k-1].g_ctl.sign_q;
            assign src_tag  = g_stage[k-1].tag_q;
        end

        always_comb begin
            data_d = src_data;
            if (src_sh[0]) begin
                case (src_op)
                    OP_LSL:  data_d = src_data << D;
                    OP_LSR:  data_d = src_data >> D;
                    OP_ASR:  data_d = (src_data >> D) | (src_sign ? ~(ONES >> D) : '0);
                    default: data_d = (src_data >> D) | (src_data << (WIDTH - D));
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q  <= 1'b0;
                data_q <= '0;
                tag_q  <= '0;
            end else if (adv) begin
                vld_q  <= src_vld;
                data_q <= data_d;
                tag_q  <= src_tag;
            end
        end

        // Control fields are only needed by later stages, so the last stage keeps none.
        if (k < SHW - 1) begin : g_ctl
            logic [1:0]     op_q;
            logic [SHR-2:0] sh_q;
            logic           sign_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    op_q   <= '0;
                    sh_q   <= '0;
                    sign_q <= 1'b0;
                end else if (adv) begin
                    op_q   <= src_op;
                    sh_q   <= src_sh[SHR-1:1];
                    sign_q <= src_sign;
                end
            end
        end

`ifdef BARREL_SHIFTER_PIPE_FLAGS_EN
        logic src_carry;
        logic carry_d;
        logic carry_q;

        if (k == 0) begin : g_cin_first
            assign src_carry = 1'b0;
        end else begin : g_cin_next
            assign src_carry = g_stage[k-1].carry_q;
        end

        // Last bit pushed out by this stage's shift, otherwise the running value.
        always_comb begin
            carry_d = src_carry;
            if (src_sh[0]) begin
                carry_d = (src_op == OP_LSL) ? src_data[WIDTH-D] : src_data[D-1];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                carry_q <= 1'b0;
            end else if (adv) begin
                carry_q <= carry_d;
            end
        end
`endif
    end

    assign out_valid = g_stage[SHW-1].vld_q;
    assign dout      = g_stage[SHW-1].data_q;
    assign tag_out   = g_stage[SHW-1].tag_q;

`ifdef BARREL_SHIFTER_PIPE_FLAGS_EN
    logic zero_q;

    // Registered alongside dout so it resets to 0 and holds under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else if (adv) begin
            zero_q <= (g_stage[SHW-1].data_d == '0);
        end
    end

    assign zero_out  = zero_q;
    assign carry_out = g_stage[SHW-1].carry_q;
`endif

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe: directed test-plan vectors, backpressure,
// mid-flight reset and randomized traffic against a bit-index reference model.
module tb_barrel_shifter_pipe;
  localparam int WIDTH = 32;
  localparam int TAG_W = 4;
  localparam int SHW   = 5;
  localparam int W     = WIDTH + TAG_W + 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din;
  logic [SHW-1:0]   shamt;
  logic [1:0]       op;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
  logic [TAG_W-1:0] tag_out;
`ifdef BARREL_SHIFTER_PIPE_FLAGS_EN
  logic             zero_out;
  logic             carry_out;
`endif

  logic [W-1:0] exp_q[$];
  int           pop_cyc_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc   = 0;
  bit           rand_done;

  barrel_shifter_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .shamt     (shamt),
    .op        (op),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .tag_out   (tag_out)
`ifdef BARREL_SHIFTER_PIPE_FLAGS_EN
    ,
    .zero_out  (zero_out),
    .carry_out (carry_out)
`endif
  );

  // clock / cycle counter / watchdog
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // reference model, defined bit by bit from the shift rules
  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d, input int n,
                                                 input logic [1:0] o);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (o)
        2'b00:   r[i] = (i >= n) ? d[i-n] : 1'b0;
        2'b01:   r[i] = (i + n < WIDTH) ? d[i+n] : 1'b0;
        2'b10:   r[i] = (i + n < WIDTH) ? d[i+n] : d[WIDTH-1];
        default: r[i] = d[(i+n)%WIDTH];
      endcase
    end
    return r;
  endfunction

  function automatic logic ref_carry(input logic [WIDTH-1:0] d, input int n, input logic [1:0] o);
    if (n == 0) return 1'b0;
    if (o == 2'b00) return d[WIDTH-n];
    return d[n-1];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // driver: present a beat, wait for the handshake, record the expected result
  task automatic send_chk(input logic [WIDTH-1:0] d, input logic [SHW-1:0] s, input logic [1:0] o,
                          input logic [TAG_W-1:0] t, input logic [WIDTH-1:0] e_data,
                          input logic e_carry);
    int waited;
    in_valid = 1'b1;
    din      = d;
    shamt    = s;
    op       = o;
    tag_in   = t;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        check("in_ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        sync();
        return;
      end
    end
    exp_q.push_back({e_carry, (e_data == '0), t, e_data});
    n_vec++;
    sync();
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic [SHW-1:0] s, input logic [1:0] o,
                      input logic [TAG_W-1:0] t);
    send_chk(d, s, o, t, ref_shift(d, int'(s), o), ref_carry(d, int'(s), o));
  endtask

  task automatic send_rand(input logic [TAG_W-1:0] t);
    send(WIDTH'($urandom), SHW'($urandom_range(0, WIDTH-1)), 2'($urandom_range(0, 3)), t);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    sync();
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && out_valid && out_ready) begin
      pop_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got dout=%0h tag=%0h, required no result", dout, tag_out);
      end else begin
        e = exp_q.pop_front();
        check("dout", 64'(dout), 64'(e[WIDTH-1:0]));
        check("tag_out", 64'(tag_out), 64'(e[WIDTH+TAG_W-1:WIDTH]));
`ifdef BARREL_SHIFTER_PIPE_FLAGS_EN
        check("zero_out", 64'(zero_out), 64'(e[W-2]));
        check("carry_out", 64'(carry_out), 64'(e[W-1]));
`endif
      end
    end
  end

  initial begin
    int lat;
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    din       = '0;
    shamt     = '0;
    op        = 2'b00;
    tag_in    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_dout", 64'(dout), 64'd0);
    check("reset_tag_out", 64'(tag_out), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
`ifdef BARREL_SHIFTER_PIPE_FLAGS_EN
    check("reset_zero_out", 64'(zero_out), 64'd0);
    check("reset_carry_out", 64'(carry_out), 64'd0);
`endif
    sync();

    // latency with an empty pipe
    send_chk(32'h0000_0001, 5'd31, 2'b00, 4'd1, 32'h8000_0000, 1'b0);
    in_valid = 1'b0;
    lat = 0;
    do begin
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 50);
    check("latency", 64'(lat), 64'(SHW));
    sync();
    drain("drain_latency");

    // directed vectors
    send_chk(32'h8000_0000, 5'd4, 2'b10, 4'd2, 32'hF800_0000, 1'b0);
    send_chk(32'h8000_0000, 5'd4, 2'b01, 4'd3, 32'h0800_0000, 1'b0);
    send_chk(32'h0000_00F1, 5'd4, 2'b11, 4'd4, 32'h1000_000F, 1'b0);
    for (int o = 0; o < 4; o++) begin
      send_chk(32'hA5C3_0F96, 5'd0, 2'(o), 4'(5 + o), 32'hA5C3_0F96, 1'b0);
    end
    send_chk(32'hFFFF_FFFF, 5'd31, 2'b00, 4'd9, 32'h8000_0000, 1'b1);
    send_chk(32'h0000_0001, 5'd1, 2'b01, 4'd10, 32'h0000_0000, 1'b1);
    send(32'h8000_0001, 5'd31, 2'b10, 4'd11);
    in_valid = 1'b0;
    drain("drain_directed");

    // back-to-back: 8 beats, results on consecutive cycles
    pop_cyc_q.delete();
    for (int t = 0; t < 8; t++) send_rand(TAG_W'(t));
    in_valid = 1'b0;
    drain("drain_b2b");
    check("b2b_count", 64'(pop_cyc_q.size()), 64'd8);
    if (pop_cyc_q.size() == 8) check("b2b_span", 64'(pop_cyc_q[7] - pop_cyc_q[0]), 64'd7);

    // backpressure: output held while out_ready is low
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_rand(TAG_W'(8 + i));
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      if (exp_q.size() > 0) begin
        check("stall_dout", 64'(dout), 64'(exp_q[0][WIDTH-1:0]));
        check("stall_tag_out", 64'(tag_out), 64'(exp_q[0][WIDTH+TAG_W-1:WIDTH]));
      end else begin
        check("stall_exp_q_size", 64'(exp_q.size()), 64'd4);
      end
    end
    sync();
    out_ready = 1'b1;
    drain("drain_backpressure");

    // reset mid-flight: in-flight beats must never emerge
    for (int i = 0; i < 3; i++) send_rand(TAG_W'(12 + i));
    in_valid = 1'b0;
    rst      = 1'b1;
    exp_q.delete();
    sync();
    rst = 1'b0;
    for (int i = 0; i < SHW + 2; i++) begin
      @(negedge clk);
      check("flush_out_valid", 64'(out_valid), 64'd0);
    end
    sync();

    // randomized traffic with random backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            sync();
          end
          send_rand(TAG_W'($urandom_range(0, 15)));
        end
        in_valid  = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          sync();
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain("drain_random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
